// File: rtl/i2s_tx_pkg.sv
// Shared audio definitions for the I2S transmit path.
// Holds default widths, the word-select encoding and a helper that maps
// a frame bit index to the word-select level carried during that bit.
package i2s_tx_pkg;

  localparam int SAMPLE_WIDTH = 12;
  localparam int SLOT_WIDTH   = 16;
  localparam int SCLK_DIV     = 4;

  typedef enum logic {
    LRCLK_LEFT  = 1'b0,
    LRCLK_RIGHT = 1'b1
  } lrclk_e;

  // Word select leads the slot by one bit: the last bit of each slot already
  // shows the level of the slot that follows.
  function automatic lrclk_e lrclk_for_bit(input int bit_idx, input int slot_w);
    return (((bit_idx + 1) % (2 * slot_w)) >= slot_w) ? LRCLK_RIGHT : LRCLK_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_sclk_gen.sv
// Bit clock generator: divides clk_i down to the I2S bit clock.
// Latency: sclk_o toggles on the clock after the divider reaches div_p-1.
// Backpressure: none; free-running, fall_o flags the edge where sclk_o drops.
module i2s_tx_sclk_gen #(
  parameter int div_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic sclk_o,
  output logic fall_o
);

  localparam int CW = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(div_p - 1);

  logic [CW-1:0] div_cnt;
  logic          sclk_lvl;
  logic          wrap;

  assign wrap = (div_cnt == DIV_LAST);

  // Half-period divider; the bit clock flips each time the divider wraps
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt  <= '0;
      sclk_lvl <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      sclk_lvl <= ~sclk_lvl;
    end else begin
      div_cnt  <= div_cnt + CW'(1);
    end
  end

  assign sclk_o = sclk_lvl;
  // High in the cycle whose closing clock edge drives sclk_o low, so the
  // parent can update its data registers on that very edge.
  assign fall_o = wrap & sclk_lvl;

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S serializer: one accepted sample fills both left and right slots.
// Latency: sample MSB appears on sdata_o at the first frame boundary after acceptance.
// Backpressure: ready_o low while the one-entry holding register is full.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int width_p      = SAMPLE_WIDTH,
  parameter int slot_width_p = SLOT_WIDTH,
  parameter int sclk_div_p   = SCLK_DIV
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic signed [width_p-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      sclk_o,
  output logic                      lrclk_o,
  output logic                      sdata_o,
  output logic                      underrun_o
);

  localparam int FRAME_BITS = 2 * slot_width_p;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int PAD        = slot_width_p - width_p;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  logic                    fall;
  logic [BW-1:0]           bit_idx;
  logic [BW-1:0]           next_bit;
  logic                    boundary;
  logic                    xfer;
  logic                    hold_empty;
  logic [width_p-1:0]      hold_data;
  logic [slot_width_p-1:0] slot;
  logic [FRAME_BITS-1:0]   frame;
  lrclk_e                  lrclk;
  logic                    underrun;

  i2s_tx_sclk_gen #(
    .div_p(sclk_div_p)
  ) u_sclk_gen (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .sclk_o   (sclk_o),
    .fall_o   (fall)
  );

  // The falling edge that closes the last bit is the frame boundary
  assign boundary = fall && (bit_idx == LAST_BIT);
  assign xfer     = valid_i && hold_empty;
  assign next_bit = boundary ? '0 : bit_idx + BW'(1);
  // Sample MSB-first, zero padded at the LSB end of the slot
  assign slot     = slot_width_p'(hold_data) << PAD;

  // Bit position and word select advance together on each sclk fall
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bit_idx <= '0;
      lrclk   <= LRCLK_LEFT;
    end else if (fall) begin
      bit_idx <= next_bit;
      lrclk   <= lrclk_for_bit(int'(next_bit), slot_width_p);
    end
  end

  // Holding register: drained by the boundary load, refilled by a handshake.
  // A full register keeps ready_o low, so drain and refill never coincide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_empty <= 1'b1;
      hold_data  <= '0;
    end else if (boundary && !hold_empty) begin
      hold_empty <= 1'b1;
    end else if (xfer) begin
      hold_empty <= 1'b0;
      hold_data  <= data_i;
    end
  end

  // Frame register: reload both slots at the boundary, else shift out MSB-first
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame <= '0;
    end else if (boundary) begin
      frame <= hold_empty ? '0 : {slot, slot};
    end else if (fall) begin
      frame <= {frame[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Underrun pulse coincides with the boundary edge that loaded silence
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      underrun <= 1'b0;
    end else begin
      underrun <= boundary && hold_empty;
    end
  end

  assign ready_o    = hold_empty;
  assign sdata_o    = frame[FRAME_BITS-1];
  assign lrclk_o    = lrclk;
  assign underrun_o = underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx with default parameters.
// A cycle-count model predicts every output each cycle; directed literals
// pin captured frames, event times and reset behaviour.
module tb_i2s_tx;

  localparam int W     = 12;
  localparam int S     = 16;
  localparam int D     = 4;
  localparam int FRAME = 4 * S * D;

  logic                clk;
  logic                rst_n;
  logic signed [W-1:0] data;
  logic                valid;
  logic                ready;
  logic                sclk;
  logic                lrclk;
  logic                sdata;
  logic                underrun;

  int checks;
  int errors;

  // model state
  int          n;
  logic        held;
  logic [W-1:0] hval;
  logic [W-1:0] cur;
  logic        und;
  logic        run_chk;

  // monitor logs
  logic [31:0] cap [16];
  int          rb;
  int          sclk_hi_win;
  int          sclk_rise_win;
  logic        ps, pl, pr;
  int          und_q[$];
  int          lr_fall_q[$];
  int          lr_rise_q[$];
  int          rdy_rise_q[$];
  int          rdy_fall_q[$];

  i2s_tx dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .sclk_o    (sclk),
    .lrclk_o   (lrclk),
    .sdata_o   (sdata),
    .underrun_o(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
    end
  endtask

  function automatic bit in_q(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_until(input int t);
    while (n < t) @(negedge clk);
  endtask

  // Offer a sample from a negedge; the transfer happens at the next posedge
  // if ready is high then. Returns on the negedge after the transfer.
  task automatic send(input logic [W-1:0] d, input int budget);
    logic took;
    took  = 1'b0;
    valid = 1'b1;
    data  = d;
    for (int i = 0; i < budget && !took; i++) begin
      took = ready;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("send_accepted", {31'd0, took}, 32'd1);
  endtask

  task automatic clear_logs();
    und_q.delete();
    lr_fall_q.delete();
    lr_rise_q.delete();
    rdy_rise_q.delete();
    rdy_fall_q.delete();
    foreach (cap[i]) cap[i] = '0;
  endtask

  // Model: n counts clock edges since reset release; frame k starts at edge k*FRAME
  // and carries whatever sample was held at that moment (silence if none).
  initial begin
    n = 0; held = 1'b0; hval = '0; cur = '0; und = 1'b0;
    forever begin
      logic xfer;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; held = 1'b0; hval = '0; cur = '0; und = 1'b0;
      end else begin
        xfer = valid && !held;
        n    = n + 1;
        und  = 1'b0;
        if (n % FRAME == 0) begin
          und  = !held;
          cur  = held ? hval : '0;
          held = 1'b0;
        end
        if (xfer) begin
          held = 1'b1;
          hval = data;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      int   bitn;
      int   p;
      logic exp_sd;
      @(negedge clk);
      if (run_chk) begin
        bitn   = (n / (2 * D)) % (2 * S);
        p      = bitn % S;
        exp_sd = 1'b0;
        if (p < W) exp_sd = cur[W-1-p];
        chk("sclk", {31'd0, sclk}, ((n / D) % 2));
        chk("lrclk", {31'd0, lrclk}, {31'd0, (((bitn + 1) % (2 * S)) >= S)});
        chk("sdata", {31'd0, sdata}, {31'd0, exp_sd});
        chk("underrun", {31'd0, underrun}, {31'd0, und});
        chk("ready", {31'd0, ready}, {31'd0, !held});
      end
    end
  end

  // Monitor: capture frames at sclk rising edges and log event cycles
  initial begin
    ps = 1'b0; pl = 1'b0; pr = 1'b1; rb = 0;
    sclk_hi_win = 0; sclk_rise_win = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps = 1'b0; pl = 1'b0; pr = 1'b1; rb = 0;
      end else begin
        if (sclk && !ps) begin
          if (rb / 32 < 16) cap[rb/32][31-(rb%32)] = sdata;
          rb++;
          if (n >= 768 && n < 1024) sclk_rise_win++;
        end
        if (sclk && n >= 768 && n < 1024) sclk_hi_win++;
        if (underrun) und_q.push_back(n);
        if (!lrclk && pl) lr_fall_q.push_back(n);
        if (lrclk && !pl) lr_rise_q.push_back(n);
        if (ready && !pr) rdy_rise_q.push_back(n);
        if (!ready && pr) rdy_fall_q.push_back(n);
        ps = sclk; pl = lrclk; pr = ready;
      end
    end
  end

  initial begin
    checks = 0; errors = 0; run_chk = 1'b0;
    valid = 1'b0; data = '0; rst_n = 1'b1;
    foreach (cap[i]) cap[i] = '0;
    #1 rst_n = 1'b0;
    run_chk = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();

    // Positive full scale, accepted during the startup frame
    wait_until(10);
    send(12'h7FF, 4);
    chk("ready_low_after_accept", {31'd0, ready}, 32'd0);

    // Negative full scale
    wait_until(620);
    send(12'h800, 4);

    // Back-to-back offer: second sample waits for the boundary drain
    wait_until(1030);
    send(12'h123, 4);
    send(12'h456, 300);

    // Handshake exactly on a boundary cycle with the holding register empty
    wait_until(2047);
    send(12'h5A5, 1);
    chk("boundary_accept_ready", {31'd0, ready}, 32'd0);

    // Sample held when reset hits mid-frame
    wait_until(2320);
    send(12'h3C3, 4);
    wait_until(2470);

    chk("frame0_zero", cap[0], 32'h0000_0000);
    chk("frame1_7ff", cap[1], 32'h7FF0_7FF0);
    chk("frame2_underrun", cap[2], 32'h0000_0000);
    chk("frame3_800", cap[3], 32'h8000_8000);
    chk("frame4_underrun", cap[4], 32'h0000_0000);
    chk("frame5_123", cap[5], 32'h1230_1230);
    chk("frame6_456", cap[6], 32'h4560_4560);
    chk("frame7_underrun", cap[7], 32'h0000_0000);
    chk("frame8_bnd_zero", cap[8], 32'h0000_0000);
    chk("frame9_left_5a5", {16'd0, cap[9][31:16]}, 32'h0000_5A50);
    chk("underrun_count", und_q.size(), 32'd4);
    if (und_q.size() == 4) begin
      chk("underrun_0", und_q[0], 32'd512);
      chk("underrun_1", und_q[1], 32'd1024);
      chk("underrun_2", und_q[2], 32'd1792);
      chk("underrun_3", und_q[3], 32'd2048);
    end
    chk("lrclk_first_rise", (lr_rise_q.size() > 0) ? lr_rise_q[0] : -1, 32'd120);
    chk("lrclk_first_fall", (lr_fall_q.size() > 0) ? lr_fall_q[0] : -1, 32'd248);
    chk("sclk_high_cycles", sclk_hi_win, 32'd128);
    chk("sclk_rises", sclk_rise_win, 32'd32);
    chk("ready_rise_1280", {31'd0, in_q(rdy_rise_q, 1280)}, 32'd1);
    chk("ready_fall_1281", {31'd0, in_q(rdy_fall_q, 1281)}, 32'd1);
    chk("ready_fall_2048", {31'd0, in_q(rdy_fall_q, 2048)}, 32'd1);

    // State just before reset: bit 20, right slot, sclk high, data bit 1
    chk("pre_rst_sclk", {31'd0, sclk}, 32'd1);
    chk("pre_rst_lrclk", {31'd0, lrclk}, 32'd1);
    chk("pre_rst_sdata", {31'd0, sdata}, 32'd1);
    chk("pre_rst_ready", {31'd0, ready}, 32'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_lrclk", {31'd0, lrclk}, 32'd0);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();

    // Held sample must be gone: startup zeros, then an underrun frame
    wait_until(600);
    chk("post_rst_frame0", cap[0], 32'h0000_0000);
    chk("post_rst_frame1", cap[1], 32'h0000_0000);
    chk("post_rst_underruns", und_q.size(), 32'd2);
    chk("post_rst_first_underrun", (und_q.size() > 0) ? und_q[0] : -1, 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serializes the signed PCM sample stream produced by the tone generators into a standard I2S frame for an external DAC. It is the consuming end of the generators' `valid`/`ready` handshake and sits between the oscillator/mixer path and the board pins. Output is mono: each accepted sample is sent in both the left and right slots.

## Interface
- `width_p`, 12, sample width in bits (signed two's complement); must satisfy `width_p` ≤ `slot_width_p`
- `slot_width_p`, 16, bits per channel slot; `width_p` sample bits MSB-first, then zero padding
- `sclk_div_p`, 4, `clk_i` cycles per `sclk_o` half-period; must be ≥ 1
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  system clock
- `reset_n_i`  in  1  asynchronous active-low reset
- `data_i`  in  `width_p`  signed sample
- `valid_i`  in  1  `data_i` valid
- `ready_o`  out  1  holding register empty; a transfer occurs when `valid_i` and `ready_o` are both high
- `sclk_o`  out  1  I2S bit clock
- `lrclk_o`  out  1  word select (0 = left, 1 = right)
- `sdata_o`  out  1  serial data
- `underrun_o`  out  1  one-cycle pulse when a frame starts with no sample held

## Operation
- One-entry holding register plus a 2·`slot_width_p`-bit frame shift register.
- `ready_o` = NOT holding_full; it is a registered output with no combinational path from `valid_i`.
- Frame: bit index b runs 0..2S−1, where S = `slot_width_p`. The left slot is bits 0..S−1 and the right slot is bits S..2S−1. Each slot carries the sample MSB-first followed by S−`width_p` zeros.
- `lrclk_o` for bit b = ((b+1) mod 2S) ≥ S. This gives the standard I2S one-bit delay: `lrclk_o` changes one bit period before the slot MSB.
- Frame boundary: the `sclk_o` falling edge that ends bit 2S−1.
  - If the holding register is full, its sample is loaded into the frame register and the holding register is cleared.
  - Otherwise the frame register loads zero and `underrun_o` pulses.
- The first frame after reset transmits zeros and does not pulse `underrun_o`.
- Simultaneous events:
  - If a handshake lands on the boundary cycle while the holding register is empty, the underrun still fires and the new sample goes into the following frame.
  - If the holding register is full on the boundary cycle, `ready_o` is low, so no transfer can occur in that cycle.
- Reset asserted mid-frame: all state clears immediately and any held sample is discarded.

## Timing
- Reset values:
  - `sclk_o` = 0, `lrclk_o` = 0, `sdata_o` = 0, `underrun_o` = 0, `ready_o` = 1
  - bit index = 0, divider = 0
- The divider counts 0..`sclk_div_p`−1. `sclk_o` toggles on the cycle after the divider reaches `sclk_div_p`−1.
  - Bit period = 2·`sclk_div_p` clocks.
  - Frame length = 4·S·`sclk_div_p` clocks; with defaults, 8 clocks per bit and 256 clocks per frame.
- `sdata_o` and `lrclk_o` change only on the same clock edge where `sclk_o` falls. They are therefore stable across the rising edge, where the DAC samples.
- `ready_o` rises on the clock after the boundary load and falls on the clock after an accepted transfer.
- Latency: the sample's MSB appears on `sdata_o` at the first frame boundary after acceptance. It appears for left then right, so the whole frame repeats the sample.
- `underrun_o` is high for exactly one clock, aligned with the boundary `sclk_o` falling edge.

## Structure
- The shared audio package holds:
  - the default sample width (12)
  - the slot width (16)
  - an `lrclk` enum for left and right
- Sub-module `sclk_gen`: divider counter plus `sclk_o` register. It outputs the `sclk_o` level and a one-cycle `fall_o` strobe.
- The top level holds the bit counter, holding register, frame shift register and handshake logic.

## Test plan
- Send 0x7FF after reset, default parameters. The first frame is all zeros. The next frame shows left slot 0111_1111_1111_0000 and right slot identical. `lrclk_o` falls 8 clocks before the left MSB.
- Send 0x800 (−2048). Each slot is 1000_0000_0000_0000. The frame spans 256 clocks and `sclk_o` has a 50% duty cycle with an 8-clock period.
- Hold `valid_i` high with 0x123 then 0x456. The first is accepted immediately. `ready_o` stays low until the next boundary, then 0x456 is accepted one clock later. The frames carry 0x123 then 0x456 in order.
- Stop sending after one sample. The following frame carries zeros and `underrun_o` pulses exactly once at that boundary. No pulse occurs after the startup frame.
- Present a valid sample exactly on the boundary cycle with the holding register empty. `underrun_o` = 1, the current frame is zero, and the sample appears in the next frame.
- Assert `reset_n_i` low at bit 20 of a frame while a sample is held. All outputs return to reset values within the same cycle. After release, the startup zero frame repeats and the held sample is lost.
